// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types for the event counter sequencer.
// Holds command opcodes, FSM state type and counter width.
package count_seq_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_START  = 3'd1,
    OP_STOP   = 3'd2,
    OP_CLEAR  = 3'd3,
    OP_LOAD   = 3'd4,
    OP_SETCMP = 3'd5
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_IDLE,
    ST_RUN
  } state_e;

endpackage

// File: rtl/count_seq_if.sv
// count_seq_if: command valid/ready channel into the sequencer.
// Signals: cmd_valid, cmd_ready, cmd_op[2:0], cmd_data[CNT_W-1:0].
interface count_seq_if;
  import count_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/pll_lock_qual.sv
// pll_lock_qual: 2-FF lock synchroniser plus settle counter.
// Ports: i_clk, i_rst, i_pll_lock (async), i_arm (FSM in
// WAIT_LOCK/SETTLE), o_lock_s (synced lock), o_settle_done.
module pll_lock_qual #(
  parameter int SETTLE_CYC = 4096
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pll_lock,
  input  logic i_arm,
  output logic o_lock_s,
  output logic o_settle_done
);

  localparam int SW = $clog2(SETTLE_CYC);
  localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [SW-1:0] r_settle_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pll_lock;
      r_sync2 <= r_sync1;
    end
  end

  // Counts consecutive synced-lock cycles, starting with the
  // first lock_s cycle seen in WAIT_LOCK, so release happens
  // after exactly SETTLE_CYC stable cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst || !r_sync2 || !i_arm) begin
      r_settle_cnt <= '0;
    end else if (r_settle_cnt != SMAX) begin
      r_settle_cnt <= r_settle_cnt + SW'(1);
    end
  end

  assign o_lock_s      = r_sync2;
  assign o_settle_done = i_arm && r_sync2 &&
                         (r_settle_cnt == SMAX);

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: PLL-lock qualified sequencer for a 32-bit
// event counter: start/stop/clear/load/compare commands.
// Ports: i_clk, i_rst (sync, high), i_pll_lock, cmd (slave),
// i_cnt_q, o_cnt_en, o_cnt_clr, o_cnt_load, o_cnt_load_val,
// o_running, o_locked, o_match.
// Option: COUNT_SEQ_PRESCALE_EN enables the PRESCALE divider.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 4096,
  parameter bit AUTO_START = 1'b1,
  parameter int PRESCALE   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pll_lock,
  count_seq_if.slave       cmd,
  input  logic [CNT_W-1:0] i_cnt_q,
  output logic             o_cnt_en,
  output logic             o_cnt_clr,
  output logic             o_cnt_load,
  output logic [CNT_W-1:0] o_cnt_load_val,
  output logic             o_running,
  output logic             o_locked,
  output logic             o_match
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_lock_s;
  logic             w_settle_done;
  logic             w_arm;
  logic             w_acc;
  logic             w_start;
  logic             w_stop;
  logic             w_clear;
  logic             w_load;
  logic             w_setcmp;
  logic             w_settle_exit;
  logic             w_eq;
  logic             w_tick;
  logic             r_cnt_clr;
  logic             r_cnt_load;
  logic             r_eq_prev;
  logic [CNT_W-1:0] r_load_val;
  logic [CNT_W-1:0] r_cmp_val;

  assign w_arm = (r_state == ST_WAIT_LOCK) ||
                 (r_state == ST_SETTLE);

  pll_lock_qual #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_qual (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pll_lock    (i_pll_lock),
    .i_arm         (w_arm),
    .o_lock_s      (w_lock_s),
    .o_settle_done (w_settle_done)
  );

  assign cmd.cmd_ready = w_lock_s &&
    ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_acc = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    w_start  = 1'b0;
    w_stop   = 1'b0;
    w_clear  = 1'b0;
    w_load   = 1'b0;
    w_setcmp = 1'b0;
    if (w_acc) begin
      unique case (1'b1)
        (cmd.cmd_op == OP_START):  w_start  = 1'b1;
        (cmd.cmd_op == OP_STOP):   w_stop   = 1'b1;
        (cmd.cmd_op == OP_CLEAR):  w_clear  = 1'b1;
        (cmd.cmd_op == OP_LOAD):   w_load   = 1'b1;
        (cmd.cmd_op == OP_SETCMP): w_setcmp = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_WAIT_LOCK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock loss overrides everything; RUN/IDLE is not
  // remembered across a resettle.
  always_comb begin
    w_state_nxt   = r_state;
    w_settle_exit = 1'b0;
    if (!w_lock_s) begin
      w_state_nxt = ST_WAIT_LOCK;
    end else begin
      unique case (r_state)
        ST_WAIT_LOCK: w_state_nxt = ST_SETTLE;
        ST_SETTLE: begin
          if (w_settle_done) begin
            w_settle_exit = 1'b1;
            w_state_nxt   = AUTO_START ? ST_RUN : ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_start) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (w_stop) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_WAIT_LOCK;
      endcase
    end
  end

  assign w_eq = (i_cnt_q == r_cmp_val);

  // r_eq_prev tracks equality in every state so a match
  // only fires on a fresh edge; SETCMP clears it to rearm.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt_clr  <= 1'b0;
      r_cnt_load <= 1'b0;
      r_load_val <= '0;
      r_cmp_val  <= '1;
      r_eq_prev  <= 1'b0;
    end else begin
      r_cnt_clr  <= w_settle_exit || w_clear;
      r_cnt_load <= w_load;
      if (w_load) r_load_val <= cmd.cmd_data;
      if (w_setcmp) r_cmp_val <= cmd.cmd_data;
      r_eq_prev  <= w_eq && !w_setcmp;
    end
  end

`ifdef COUNT_SEQ_PRESCALE_EN
  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic          w_run_entry;

  assign w_run_entry = (w_state_nxt == ST_RUN) &&
                       (r_state != ST_RUN);
  assign w_tick = (r_presc == PMAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
    end else if (w_run_entry || w_clear || w_load) begin
      r_presc <= '0;
    end else if (r_state == ST_RUN) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end
`else
  logic w_unused_presc;
  assign w_unused_presc = |PRESCALE;
  assign w_tick = 1'b1;
`endif

  assign o_running      = (r_state == ST_RUN);
  assign o_locked       = (r_state == ST_IDLE) ||
                          (r_state == ST_RUN);
  assign o_cnt_clr      = r_cnt_clr;
  assign o_cnt_load     = r_cnt_load;
  assign o_cnt_load_val = r_load_val;
  assign o_cnt_en       = o_running && w_lock_s && w_tick &&
                          !r_cnt_clr && !r_cnt_load;
  assign o_match        = o_running && w_eq && !r_eq_prev;

endmodule
